// File: rtl/fb_axi_pkg.sv
// Shared types and AXI constants for the framebuffer stream-to-AXI bridge.
package fb_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WADDR,
        ST_WDATA,
        ST_WRESP,
        ST_RADDR,
        ST_RDATA
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axsize(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/fb_stream_axi_bridge_if.sv
// AXI4 master-side bundle (AW/W/B/AR/R) between the bridge and external memory.
interface fb_stream_axi_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/fb_axi_burst_splitter.sv
// Carves the next INCR burst out of a transfer: never crosses a MAX_BURST_LEN-beat
// aligned window, so the 4 KB rule holds whenever the window is at most 4 KB.
module fb_axi_burst_splitter #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [ADDR_WIDTH-1:0] rem_i,
    output logic [ADDR_WIDTH-1:0] len_o,
    output logic [ADDR_WIDTH-1:0] next_addr_o,
    output logic [ADDR_WIDTH-1:0] next_rem_o
);
    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] WINDOW_MASK = ADDR_WIDTH'(MAX_BURST_LEN * (DATA_WIDTH / 8) - 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_LEN     = ADDR_WIDTH'(MAX_BURST_LEN);

    logic [ADDR_WIDTH-1:0] to_bound;

    // Beats left to the window edge is always <= MAX_BURST_LEN, so it also caps L.
    always_comb begin
        to_bound    = MAX_LEN - ((addr_i & WINDOW_MASK) >> BEAT_SHIFT);
        len_o       = (rem_i < to_bound) ? rem_i : to_bound;
        next_addr_o = addr_i + (len_o << BEAT_SHIFT);
        next_rem_o  = rem_i - len_o;
    end

endmodule

// File: rtl/fb_stream_axi_bridge.sv
// Turns framebuffer memory requests plus AXI-Stream data into sequential AXI4 INCR
// bursts (one outstanding) and streams read data back with zero latency.
module fb_stream_axi_bridge
    import fb_axi_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_avalid,
    output logic                    s_aready,
    input  logic [ADDR_WIDTH-1:0]   s_aaddr,
    input  logic [ADDR_WIDTH-1:0]   s_abeats,
    input  logic                    s_arnw,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    fb_stream_axi_bridge_if.master  m_axi,
    output logic                    busy,
    output logic                    error
);
    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rem_q;
    logic [7:0]            cnt_q;
    logic                  awvalid_q;
    logic                  arvalid_q;
    logic                  error_q;
    logic                  rdy_q;

    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] next_rem;
    logic [7:0]            len_m1;
    logic                  req_hs, w_hs, b_hs, r_hs;
    logic                  unused_inputs;

    fb_axi_burst_splitter #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MAX_BURST_LEN (MAX_BURST_LEN)
    ) u_split (
        .addr_i      (addr_q),
        .rem_i       (rem_q),
        .len_o       (len),
        .next_addr_o (next_addr),
        .next_rem_o  (next_rem)
    );

    // Beat count, not the incoming tlast, delimits bursts; IDs are not checked.
    assign unused_inputs = ^{s_axis_tlast, m_axi.bid, m_axi.rid};

    assign len_m1 = 8'(len - ADDR_WIDTH'(1));
    assign req_hs = rdy_q && (state_q == ST_IDLE) && s_avalid;
    assign w_hs   = (state_q == ST_WDATA) && s_axis_tvalid && m_axi.wready;
    assign b_hs   = (state_q == ST_WRESP) && m_axi.bvalid;
    assign r_hs   = (state_q == ST_RDATA) && m_axi.rvalid && m_axis_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            awvalid_q <= 1'b0;
            arvalid_q <= 1'b0;
            error_q   <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (req_hs) begin
                        addr_q <= s_aaddr;
                        rem_q  <= s_abeats;
                        if (s_abeats != '0) begin
                            state_q   <= s_arnw ? ST_RADDR : ST_WADDR;
                            awvalid_q <= ~s_arnw;
                            arvalid_q <= s_arnw;
                        end
                    end
                end
                ST_WADDR: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == len_m1) state_q <= ST_WRESP;
                    end
                end
                ST_WRESP: begin
                    if (b_hs) begin
                        if (m_axi.bresp != AXI_RESP_OKAY) error_q <= 1'b1;
                        rem_q <= next_rem;
                        if (next_rem == '0) begin
                            state_q <= ST_IDLE;
                        end else begin
                            addr_q    <= next_addr;
                            awvalid_q <= 1'b1;
                            state_q   <= ST_WADDR;
                        end
                    end
                end
                ST_RADDR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_hs) begin
                        if (m_axi.rresp != AXI_RESP_OKAY) error_q <= 1'b1;
                        if (m_axi.rlast) begin
                            rem_q <= next_rem;
                            if (next_rem == '0) begin
                                state_q <= ST_IDLE;
                            end else begin
                                addr_q    <= next_addr;
                                arvalid_q <= 1'b1;
                                state_q   <= ST_RADDR;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axi.awid    = '0;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_m1;
    assign m_axi.awsize  = axsize(DATA_WIDTH);
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wdata   = s_axis_tdata;
    assign m_axi.wstrb   = s_axis_tstrb;
    assign m_axi.wlast   = (state_q == ST_WDATA) && (cnt_q == len_m1);
    assign m_axi.wvalid  = (state_q == ST_WDATA) && s_axis_tvalid;
    assign s_axis_tready = (state_q == ST_WDATA) && m_axi.wready;

    assign m_axi.bready  = (state_q == ST_WRESP);

    assign m_axi.arid    = '0;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_m1;
    assign m_axi.arsize  = axsize(DATA_WIDTH);
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arvalid = arvalid_q;

    assign m_axi.rready  = (state_q == ST_RDATA) && m_axis_tready;
    assign m_axis_tvalid = (state_q == ST_RDATA) && m_axi.rvalid;
    assign m_axis_tdata  = m_axi.rdata;
    // Only the final burst's rlast closes the framebuffer-side packet.
    assign m_axis_tlast  = (state_q == ST_RDATA) && m_axi.rlast && (rem_q == len);

    assign s_aready = rdy_q && (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign error    = error_q;

endmodule
